stage1_exec_ctrl: RTL and testbench
===================================

Name: stage1_exec_ctrl

Overview:
Parametrised stage-1 execute controller for the accumulator processor. It accepts one decoded instruction at a time from stage 0 over a valid/ready handshake. It sequences operand fetch (immediate, direct or indirect) through the data cache with real miss stalls and a miss timeout, then drives ALU, shifter, branch and return strobes. Multiply and divide by a power of two run through the shifter, and the data and shift widths are parametrised.

Parameters:
DATA_W, 8, width of ir_data and mdr_data.
SHAMT_W, 3, shift-amount width; must equal clog2(DATA_W).
MISS_TIMEOUT, 15, maximum consecutive cycles without cache_hit in any read state before the operation aborts.

Ports:
clk  in  1  clock; all state changes on its rising edge
clr  in  1  reset; one clock domain, synchronous, active-high
instr_valid  in  1  stage-0 handshake: instr is valid
instr  in  8  opcode in [7:3], flag in [2:0]
ir_data  in  DATA_W  immediate value, address, or shift amount
mdr_data  in  DATA_W  memory data register contents
cache_hit  in  1  data cache returned the addressed word this cycle
stg1_ready  out  1  stage-1 handshake: idle, can accept an instruction
mem_rd  out  1  data read request
addr_sel  out  1  read address source: 0 = ir_data, 1 = mdr_data
mdr_load  out  1  load the MDR from the cache
alu_op  out  3  ADD=0, SUB=1, OR=2, AND=3, COMP=4
alu_imm  out  1  ALU B operand source: 1 = ir_data, 0 = mdr_data
acc_load  out  1  write the ALU or shifter result to the accumulator
shift_en  out  1  shifter drives the accumulator path
shift_dir  out  1  0 = left, 1 = right
shift_fill  out  1  fill bit shifted in
num_shift  out  SHAMT_W  shift amount
pc_load  out  1  branch taken
ret_pop  out  1  pop the return stack (RTS and RTI)
irq_restore  out  1  restore interrupt state (RTI only)
err_illegal  out  1  one-cycle pulse: unsupported opcode or flag
err_timeout  out  1  one-cycle pulse: cache miss timeout

Behaviour:
- States (binary-encoded enum): IDLE, RD_PTR, RD_OPD, EXEC, SHIFT, BRANCH, RETURN, ERR_ILL, ERR_TO.
- Outputs are Moore outputs of the registered state, except mdr_load = cache_hit in RD_PTR or RD_OPD.
- Reset: state IDLE. stg1_ready=1; every other output 0; num_shift=0; miss counter=0. Reset overrides any in-flight operation, and no strobe fires on the cycle after reset.
- IDLE: stg1_ready=1. When instr_valid=1, instr, ir_data and the operand mode are captured on the edge. stg1_ready is low from the next cycle until the block returns to IDLE. While busy, instr_valid is ignored.
- Dispatch from IDLE:
  - ADD/SUB/OR/AND, flag 000 (direct) -> RD_OPD.
  - ADD/SUB/OR/AND, flag 001 (indirect) -> RD_PTR.
  - ADD/SUB/OR/AND, flag 010 (immediate) -> EXEC with alu_imm=1.
  - COMP -> EXEC.
  - MULDIV, flags 000/010 (direct) -> RD_OPD; flags 001/011 (indirect) -> RD_PTR.
  - SHFT, flags 000-011 -> SHIFT.
  - BRA -> BRANCH. RTS and RTI -> RETURN. NOP -> stays IDLE.
  - Any other opcode or flag -> ERR_ILL.
- RD_PTR: mem_rd=1, addr_sel=0. Holds until cache_hit, then -> RD_OPD.
- RD_OPD: mem_rd=1. addr_sel=0 for direct, 1 for indirect. On cache_hit: -> EXEC for ALU ops, -> SHIFT for MULDIV.
- Miss counter:
  - Cleared on entry to each read state.
  - Increments every cycle in the state without cache_hit.
  - When it reaches MISS_TIMEOUT without a hit -> ERR_TO.
  - cache_hit in the same cycle takes priority over the timeout.
- EXEC: one cycle; acc_load=1 with the decoded alu_op; -> IDLE.
- SHIFT: one cycle; shift_en=1, acc_load=1; -> IDLE.
  - SHFT flag 000 LS0, 001 LS1, 010 RS0, 011 RS1, giving shift_dir=flag[1] and shift_fill=flag[0]; num_shift = captured ir_data[SHAMT_W-1:0].
  - MULDIV: shift_dir = flag[1] (multiply left, divide right), shift_fill=0, num_shift = mdr_data[SHAMT_W-1:0].
- BRANCH: pc_load=1 for one cycle. RETURN: ret_pop=1, plus irq_restore=1 for RTI. Both -> IDLE.
- ERR_ILL and ERR_TO: the matching err pulse for one cycle, no acc_load; -> IDLE.
- Latency (accept edge = cycle 0):
  - Immediate: acc_load in cycle 1, stg1_ready in cycle 2.
  - Direct with immediate hit: acc_load in cycle 2, ready in cycle 3.
  - Indirect with immediate hits: acc_load in cycle 3.
  - Each miss cycle adds one cycle.
- cache_hit outside the read states is ignored.

Decomposition:
- Package stage1_pkg holds:
  - opcode constants (ADD 00000, SUB 00001, MULDIV 00010, OR 00011, AND 00100, SHFT 00101, BRA 00110, RTS 01000, RTI 01001, NOP 01111, COMP 10000);
  - flag constants;
  - alu_op encodings;
  - the state enum.
- One sub-module, stage1_miss_timer: the miss counter with clear, count and expired outputs.

Test Plan:
- Reset with clr=1 mid-RD_OPD -> next cycle IDLE, stg1_ready=1, all strobes 0, no acc_load.
- ADD immediate (instr=00000_010, ir_data=0x05) -> alu_op=0, alu_imm=1, acc_load in cycle 1, stg1_ready=1 in cycle 2.
- SUB indirect (instr=00001_001) with cache_hit after 2 miss cycles on each read -> addr_sel 0 then 1, two mdr_load pulses, acc_load with alu_op=1 in cycle 7.
- MULDIV divide direct (instr=00010_010, mdr_data=0x03 at hit) -> shift_dir=1, shift_fill=0, num_shift=3, acc_load=1.
- SHFT RS1 (instr=00101_011, ir_data=0x06) -> shift_dir=1, shift_fill=1, num_shift=6. Illegal instr=01010_000 -> single err_illegal pulse, then stg1_ready.
- Direct read with cache_hit held low -> err_timeout after exactly 15 miss cycles, no acc_load. Repeat with the hit on the 15th cycle -> normal completion, no error.

Source files
------------

// File: rtl/stage1_pkg.sv
// Shared definitions for the stage-1 execute controller: opcode and flag
// encodings, ALU operation codes, the FSM state type and the per-instruction
// context captured at dispatch.
package stage1_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_MULDIV = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_AND    = 5'b00100;
  localparam logic [4:0] OP_SHFT   = 5'b00101;
  localparam logic [4:0] OP_BRA    = 5'b00110;
  localparam logic [4:0] OP_RTS    = 5'b01000;
  localparam logic [4:0] OP_RTI    = 5'b01001;
  localparam logic [4:0] OP_NOP    = 5'b01111;
  localparam logic [4:0] OP_COMP   = 5'b10000;

  // ALU operand modes
  localparam logic [2:0] FL_DIRECT   = 3'b000;
  localparam logic [2:0] FL_INDIRECT = 3'b001;
  localparam logic [2:0] FL_IMM      = 3'b010;
  // Shift variants: flag[1] is direction, flag[0] is the fill bit
  localparam logic [2:0] FL_LS0 = 3'b000;
  localparam logic [2:0] FL_LS1 = 3'b001;
  localparam logic [2:0] FL_RS0 = 3'b010;
  localparam logic [2:0] FL_RS1 = 3'b011;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_OR   = 3'd2,
    ALU_AND  = 3'd3,
    ALU_COMP = 3'd4
  } alu_op_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_PTR  = 4'd1,
    ST_RD_OPD  = 4'd2,
    ST_EXEC    = 4'd3,
    ST_SHIFT   = 4'd4,
    ST_BRANCH  = 4'd5,
    ST_RETURN  = 4'd6,
    ST_ERR_ILL = 4'd7,
    ST_ERR_TO  = 4'd8
  } state_t;

  // Everything later states need to know about the accepted instruction.
  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_imm;
    logic    indirect;
    logic    muldiv;
    logic    shift_dir;
    logic    shift_fill;
    logic    rti;
  } op_ctx_t;

endpackage

// File: rtl/stage1_exec_ctrl_if.sv
// Stage-0 / data-cache / datapath signals of the stage-1 execute controller.
// master: the driving side (stage 0, cache, bench); slave: the controller.
interface stage1_exec_ctrl_if #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3
);
  logic               instr_valid;
  logic [7:0]         instr;
  logic [DATA_W-1:0]  ir_data;
  logic [DATA_W-1:0]  mdr_data;
  logic               cache_hit;
  logic               stg1_ready;
  logic               mem_rd;
  logic               addr_sel;
  logic               mdr_load;
  logic [2:0]         alu_op;
  logic               alu_imm;
  logic               acc_load;
  logic               shift_en;
  logic               shift_dir;
  logic               shift_fill;
  logic [SHAMT_W-1:0] num_shift;
  logic               pc_load;
  logic               ret_pop;
  logic               irq_restore;
  logic               err_illegal;
  logic               err_timeout;

  modport master (
    output instr_valid, instr, ir_data, mdr_data, cache_hit,
    input  stg1_ready, mem_rd, addr_sel, mdr_load, alu_op, alu_imm, acc_load,
           shift_en, shift_dir, shift_fill, num_shift, pc_load, ret_pop,
           irq_restore, err_illegal, err_timeout
  );

  modport slave (
    input  instr_valid, instr, ir_data, mdr_data, cache_hit,
    output stg1_ready, mem_rd, addr_sel, mdr_load, alu_op, alu_imm, acc_load,
           shift_en, shift_dir, shift_fill, num_shift, pc_load, ret_pop,
           irq_restore, err_illegal, err_timeout
  );
endinterface

// File: rtl/stage1_miss_timer.sv
// Consecutive cache-miss counter for the read states.
// Ports: clk, clr (sync reset), clear (restart on state entry),
// count (a miss this cycle), expired (this miss is the MISS_TIMEOUT-th).
module stage1_miss_timer #(
  parameter int MISS_TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic count,
  output logic expired
);
  localparam int CW = $clog2(MISS_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, whatever the block ordering.
  always_ff @(posedge clk) begin
    if (clr || clear) cnt <= '0;
    else if (count)   cnt <= cnt + 1'b1;
  end

  // Fires during the miss that would complete the budget; a hit in the same
  // cycle deasserts count and therefore wins.
  assign expired = count && (cnt == CW'(MISS_TIMEOUT - 1));

endmodule

// File: rtl/stage1_exec_ctrl.sv
// Stage-1 execute controller of the accumulator processor.
// Accepts one decoded instruction from stage 0 (instr_valid/stg1_ready),
// fetches the operand through the data cache (immediate, direct, indirect)
// with miss stalls and a miss timeout, then strobes ALU, shifter, branch or
// return control for one cycle.
// Ports: clk, clr (sync active-high reset), bus (stage1_exec_ctrl_if.slave).
module stage1_exec_ctrl
  import stage1_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int SHAMT_W      = 3,
  parameter int MISS_TIMEOUT = 15
) (
  input logic                clk,
  input logic                clr,
  stage1_exec_ctrl_if.slave  bus
);

  state_t              state, state_d, disp;
  op_ctx_t             ctx, ctx_dec;
  logic [SHAMT_W-1:0]  shamt;
  logic [4:0]          opcode;
  logic [2:0]          flag;
  logic                in_rd, timer_clear, timer_count, timer_expired;

  assign opcode = bus.instr[7:3];
  assign flag   = bus.instr[2:0];
  assign in_rd  = (state == ST_RD_PTR) || (state == ST_RD_OPD);

  // Dispatch target and context for the instruction on the bus.
  // NOTE: every always_comb output gets a default first so no path can leave
  // a variable unassigned and infer a latch.
  always_comb begin
    ctx_dec = '0;
    disp    = ST_ERR_ILL;
    case (opcode)
      OP_SUB:  ctx_dec.alu_op = ALU_SUB;
      OP_OR:   ctx_dec.alu_op = ALU_OR;
      OP_AND:  ctx_dec.alu_op = ALU_AND;
      OP_COMP: ctx_dec.alu_op = ALU_COMP;
      default: ctx_dec.alu_op = ALU_ADD;
    endcase
    case (opcode)
      OP_ADD, OP_SUB, OP_OR, OP_AND: begin
        case (flag)
          FL_DIRECT:   disp = ST_RD_OPD;
          FL_INDIRECT: begin disp = ST_RD_PTR; ctx_dec.indirect = 1'b1; end
          FL_IMM:      begin disp = ST_EXEC;   ctx_dec.alu_imm  = 1'b1; end
          default:     disp = ST_ERR_ILL;
        endcase
      end
      OP_COMP: disp = ST_EXEC;
      OP_MULDIV: begin
        // flag[0] selects indirect addressing, flag[1] divide (right shift)
        if (!flag[2]) begin
          ctx_dec.muldiv    = 1'b1;
          ctx_dec.indirect  = flag[0];
          ctx_dec.shift_dir = flag[1];
          disp = flag[0] ? ST_RD_PTR : ST_RD_OPD;
        end
      end
      OP_SHFT: begin
        if (!flag[2]) begin
          ctx_dec.shift_dir  = flag[1];
          ctx_dec.shift_fill = flag[0];
          disp = ST_SHIFT;
        end
      end
      OP_BRA:  disp = ST_BRANCH;
      OP_RTS:  disp = ST_RETURN;
      OP_RTI:  begin disp = ST_RETURN; ctx_dec.rti = 1'b1; end
      OP_NOP:  disp = ST_IDLE;
      default: disp = ST_ERR_ILL;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (bus.instr_valid) state_d = disp;
      ST_RD_PTR: begin
        if (bus.cache_hit)  state_d = ST_RD_OPD;
        else if (timer_expired) state_d = ST_ERR_TO;
      end
      ST_RD_OPD: begin
        if (bus.cache_hit)  state_d = ctx.muldiv ? ST_SHIFT : ST_EXEC;
        else if (timer_expired) state_d = ST_ERR_TO;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Restarting on every state change covers entry into each read state,
  // including the RD_PTR -> RD_OPD hand-over.
  assign timer_clear = (state_d != state);
  assign timer_count = in_rd && !bus.cache_hit;

  stage1_miss_timer #(.MISS_TIMEOUT(MISS_TIMEOUT)) u_miss_timer (
    .clk     (clk),
    .clr     (clr),
    .clear   (timer_clear),
    .count   (timer_count),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      ctx   <= '0;
      shamt <= '0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && bus.instr_valid) begin
        ctx   <= ctx_dec;
        shamt <= bus.ir_data[SHAMT_W-1:0];
      end
    end
  end

  // Moore outputs of the registered state; mdr_load follows the hit directly.
  always_comb begin
    bus.stg1_ready  = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.addr_sel    = 1'b0;
    bus.mdr_load    = 1'b0;
    bus.alu_op      = 3'd0;
    bus.alu_imm     = 1'b0;
    bus.acc_load    = 1'b0;
    bus.shift_en    = 1'b0;
    bus.shift_dir   = 1'b0;
    bus.shift_fill  = 1'b0;
    bus.num_shift   = '0;
    bus.pc_load     = 1'b0;
    bus.ret_pop     = 1'b0;
    bus.irq_restore = 1'b0;
    bus.err_illegal = 1'b0;
    bus.err_timeout = 1'b0;
    case (state)
      ST_IDLE:   bus.stg1_ready = 1'b1;
      ST_RD_PTR: begin
        bus.mem_rd   = 1'b1;
        bus.mdr_load = bus.cache_hit;
      end
      ST_RD_OPD: begin
        bus.mem_rd   = 1'b1;
        bus.addr_sel = ctx.indirect;
        bus.mdr_load = bus.cache_hit;
      end
      ST_EXEC: begin
        bus.acc_load = 1'b1;
        bus.alu_op   = ctx.alu_op;
        bus.alu_imm  = ctx.alu_imm;
      end
      ST_SHIFT: begin
        bus.acc_load   = 1'b1;
        bus.shift_en   = 1'b1;
        bus.shift_dir  = ctx.shift_dir;
        bus.shift_fill = ctx.shift_fill;
        // MULDIV takes its power of two from the operand just loaded into MDR
        bus.num_shift  = ctx.muldiv ? bus.mdr_data[SHAMT_W-1:0] : shamt;
      end
      ST_BRANCH: bus.pc_load = 1'b1;
      ST_RETURN: begin
        bus.ret_pop     = 1'b1;
        bus.irq_restore = ctx.rti;
      end
      ST_ERR_ILL: bus.err_illegal = 1'b1;
      ST_ERR_TO:  bus.err_timeout = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stage1_exec_ctrl.sv
// Self-checking bench for stage1_exec_ctrl. Inputs change on the falling edge,
// outputs are sampled 1 ns later. Cycle n is the period after rising edge n,
// with the accepting edge numbered 0.
module tb_stage1_exec_ctrl;
  import stage1_pkg::*;

  localparam int DATA_W = 8, SHAMT_W = 3, MISS_TIMEOUT = 15;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  stage1_exec_ctrl_if #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) bus ();

  stage1_exec_ctrl #(
    .DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .MISS_TIMEOUT(MISS_TIMEOUT)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    int          cyc;
    logic [15:0] strobes;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] obs_strobes();
    return {bus.acc_load, bus.alu_op, bus.alu_imm, bus.shift_en, bus.shift_dir,
            bus.shift_fill, bus.num_shift, bus.pc_load, bus.ret_pop,
            bus.irq_restore, bus.err_illegal, bus.err_timeout};
  endfunction

  function automatic logic [15:0] mk(input logic acc, input logic [2:0] op,
                                     input logic imm, input logic sh,
                                     input logic dir, input logic fill,
                                     input logic [2:0] num, input logic pc,
                                     input logic ret, input logic irq,
                                     input logic ill, input logic to);
    return {acc, op, imm, sh, dir, fill, num, pc, ret, irq, ill, to};
  endfunction

  function automatic logic completion();
    return bus.acc_load | bus.pc_load | bus.ret_pop | bus.err_illegal | bus.err_timeout;
  endfunction

  // Issues one instruction, pushes its expected result, then plays hit_pat
  // (bit k = cache_hit in cycle k+1) until a completion strobe appears.
  task automatic run_op(input string tag, input logic [7:0] ins,
                        input logic [7:0] ir, input logic [7:0] mdr,
                        input logic [39:0] hit_pat, input logic [15:0] exp_str,
                        input int exp_cyc, output int mdr_pulses,
                        output logic [15:0] addr_trace, output int rd_cycles);
    int   waited;
    logic done;
    exp_t e;
    @(negedge clk);
    waited = 0;
    while (bus.stg1_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " ready_before"}, bus.stg1_ready, 1);
    sb.push_back('{tag: tag, cyc: exp_cyc, strobes: exp_str});
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.ir_data     = ir;
    bus.mdr_data    = mdr;
    bus.cache_hit   = 1'b0;
    mdr_pulses = 0;
    addr_trace = '0;
    rd_cycles  = 0;
    done       = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr       = 8'hff;
      bus.cache_hit   = hit_pat[cyc-1];
      #1;
      if (bus.mem_rd === 1'b1 && rd_cycles < 16) begin
        addr_trace[rd_cycles] = bus.addr_sel;
        rd_cycles++;
      end
      if (bus.mdr_load === 1'b1) mdr_pulses++;
      if (completion() === 1'b1) begin
        e = sb.pop_front();
        check({e.tag, " strobes"}, obs_strobes(), e.strobes);
        check({e.tag, " cycle"}, cyc, e.cyc);
        done = 1'b1;
      end else begin
        check({tag, " busy_not_ready"}, bus.stg1_ready, 0);
      end
    end
    check({tag, " completed"}, done, 1);
    if (!done && sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    bus.cache_hit = 1'b0;
    #1;
    check({tag, " ready_after"}, bus.stg1_ready, 1);
    check({tag, " quiet_after"}, obs_strobes(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          mp, rc;
    logic [15:0] at;

    clr = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    bus.ir_data     = '0;
    bus.mdr_data    = '0;
    bus.cache_hit   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset ready", bus.stg1_ready, 1);
    check("reset strobes", obs_strobes(), 0);
    check("reset mem_rd", {bus.mem_rd, bus.addr_sel, bus.mdr_load}, 0);
    clr = 1'b0;

    run_op("add_imm", 8'b00000_010, 8'h05, 8'h00, 40'h0,
           mk(1, 3'd0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0), 1, mp, at, rc);
    check("add_imm no_read", rc, 0);

    run_op("sub_ind", 8'b00001_001, 8'h20, 8'h40, 40'b100100,
           mk(1, 3'd1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0), 7, mp, at, rc);
    check("sub_ind mdr_pulses", mp, 2);
    check("sub_ind rd_cycles", rc, 6);
    check("sub_ind addr_sel", at[5:0], 6'b111000);

    run_op("div_dir", 8'b00010_010, 8'h30, 8'h03, 40'b1,
           mk(1, 3'd0, 0, 1, 1, 0, 3'd3, 0, 0, 0, 0, 0), 2, mp, at, rc);
    check("div_dir rd", {rc[7:0], at[0]}, {8'd1, 1'b0});

    run_op("mul_ind", 8'b00010_001, 8'h30, 8'h05, 40'b11,
           mk(1, 3'd0, 0, 1, 0, 0, 3'd5, 0, 0, 0, 0, 0), 3, mp, at, rc);
    check("mul_ind addr_sel", at[1:0], 2'b10);

    run_op("shft_rs1", 8'b00101_011, 8'h06, 8'h00, 40'h0,
           mk(1, 3'd0, 0, 1, 1, 1, 3'd6, 0, 0, 0, 0, 0), 1, mp, at, rc);
    run_op("shft_ls0", 8'b00101_000, 8'h0a, 8'h07, 40'h0,
           mk(1, 3'd0, 0, 1, 0, 0, 3'd2, 0, 0, 0, 0, 0), 1, mp, at, rc);

    run_op("illegal_op", 8'b01010_000, 8'h00, 8'h00, 40'h0,
           mk(0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0), 1, mp, at, rc);
    run_op("illegal_flag", 8'b00000_011, 8'h00, 8'h00, 40'h0,
           mk(0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0), 1, mp, at, rc);

    run_op("timeout", 8'b00000_000, 8'h10, 8'h00, 40'h0,
           mk(0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1), 16, mp, at, rc);
    check("timeout miss_cycles", rc, 15);
    run_op("hit_on_15", 8'b00000_000, 8'h10, 8'h00, 40'h1 << 14,
           mk(1, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0), 16, mp, at, rc);
    check("hit_on_15 mdr_pulses", mp, 1);

    run_op("bra", 8'b00110_000, 8'h00, 8'h00, {40{1'b1}},
           mk(0, 3'd0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0), 1, mp, at, rc);
    check("bra ignores hit", {rc[7:0], mp[7:0]}, 16'h0);
    run_op("rti", 8'b01001_000, 8'h00, 8'h00, 40'h0,
           mk(0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 1, 0, 0), 1, mp, at, rc);
    run_op("rts", 8'b01000_000, 8'h00, 8'h00, 40'h0,
           mk(0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 0, 0), 1, mp, at, rc);
    run_op("comp", 8'b10000_000, 8'h00, 8'h00, 40'h0,
           mk(1, 3'd4, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0), 1, mp, at, rc);
    run_op("or_dir", 8'b00011_000, 8'h11, 8'h22, 40'h1,
           mk(1, 3'd2, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0), 2, mp, at, rc);
    run_op("and_imm", 8'b00100_010, 8'h33, 8'h00, 40'h0,
           mk(1, 3'd3, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0), 1, mp, at, rc);

    // NOP: accepted but the block never leaves IDLE
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 8'b01111_000;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    #1;
    check("nop ready", bus.stg1_ready, 1);
    check("nop strobes", obs_strobes(), 0);

    // Reset while stalled in RD_OPD, with a hit offered on the reset cycle
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 8'b00000_000;
    bus.cache_hit   = 1'b0;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    #1;
    check("rst_mid in_rd_opd", {bus.mem_rd, bus.stg1_ready}, 2'b10);
    @(negedge clk);
    clr = 1'b1;
    bus.cache_hit = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    bus.cache_hit = 1'b0;
    #1;
    check("rst_mid ready", bus.stg1_ready, 1);
    check("rst_mid strobes", obs_strobes(), 0);
    check("rst_mid mem_rd", {bus.mem_rd, bus.mdr_load}, 0);
    @(negedge clk);
    #1;
    check("rst_mid no_late_acc", {bus.acc_load, bus.stg1_ready}, 2'b01);

    check("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
